// File: rtl/mudv_ctl_if.sv
// Bus between the E stage and the multiply/divide sequencing controller.
// The E stage (master) drives commands and operands; the controller (slave)
// returns busy/stall, the architectural HI/LO and the move-from result.
interface mudv_ctl_if;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  wen;
  logic [1:0]  rsel;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (
    output start, op, wen, rsel, rs, rt,
    input  busy, stall, hi, lo, rdata
  );

  modport slave (
    input  start, op, wen, rsel, rs, rt,
    output busy, stall, hi, lo, rdata
  );
endinterface

// File: rtl/mudv_ctl.sv
// Multiply/divide sequencing controller. Owns HI/LO, computes results at
// accept time, then holds busy for a fixed latency before committing them.
// A stall is requested whenever an E-stage MUDV access meets a busy unit.
module mudv_ctl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  mudv_ctl_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      pend_hi_r;
  logic [31:0]      pend_lo_r;
  logic             pend_wr_r;

  logic             accept_s;
  logic             is_signed_s;
  logic [63:0]      mul_a_s;
  logic [63:0]      mul_b_s;
  logic [63:0]      prod_s;
  logic [31:0]      mag_a_s;
  logic [31:0]      mag_b_s;
  logic [31:0]      div_b_s;
  logic [31:0]      q_mag_s;
  logic [31:0]      r_mag_s;
  logic [31:0]      quot_s;
  logic [31:0]      rem_s;
  logic [31:0]      res_hi_s;
  logic [31:0]      res_lo_s;
  logic             res_wr_s;

  assign accept_s    = (state_r == IDLE) && bus.start && !bus.op[2];
  assign is_signed_s = !bus.op[0];

  // Result datapath: one multiplier and one unsigned divider shared by the
  // signed and unsigned forms (signed division works on magnitudes).
  always_comb begin
    mul_a_s  = {{32{is_signed_s & bus.rs[31]}}, bus.rs};
    mul_b_s  = {{32{is_signed_s & bus.rt[31]}}, bus.rt};
    prod_s   = mul_a_s * mul_b_s;
    mag_a_s  = (is_signed_s && bus.rs[31]) ? (32'd0 - bus.rs) : bus.rs;
    mag_b_s  = (is_signed_s && bus.rt[31]) ? (32'd0 - bus.rt) : bus.rt;
    // Keep the divider defined when the divisor is zero; results are dropped.
    div_b_s  = (mag_b_s == 32'd0) ? 32'd1 : mag_b_s;
    q_mag_s  = mag_a_s / div_b_s;
    r_mag_s  = mag_a_s % div_b_s;
    quot_s   = (is_signed_s && (bus.rs[31] ^ bus.rt[31])) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s    = (is_signed_s && bus.rs[31]) ? (32'd0 - r_mag_s) : r_mag_s;
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    res_wr_s = 1'b0;
    if (bus.op[1] == 1'b0) begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
      res_wr_s = 1'b1;
    end else begin
      res_hi_s = rem_s;
      res_lo_s = quot_s;
      res_wr_s = (bus.rt != 32'd0);
    end
  end

  // Sequencer: accept, count down the fixed latency, commit HI/LO; move-to in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            pend_hi_r <= res_hi_s;
            pend_lo_r <= res_lo_s;
            pend_wr_r <= res_wr_s;
            cnt_r     <= bus.op[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            state_r   <= RUN;
          end else if (!bus.start && (bus.wen == 2'b10)) begin
            hi_r <= bus.rs;
          end else if (!bus.start && (bus.wen == 2'b01)) begin
            lo_r <= bus.rs;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            if (pend_wr_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end else begin
              hi_r <= hi_r;
            end
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Move-from mux over the architectural HI/LO.
  always_comb begin
    case (bus.rsel)
      2'b10:   bus.rdata = hi_r;
      2'b01:   bus.rdata = lo_r;
      default: bus.rdata = 32'd0;
    endcase
  end

  assign bus.busy  = (state_r == RUN);
  assign bus.stall = bus.busy & (bus.start | (bus.wen != 2'b00) | (bus.rsel != 2'b00));
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

endmodule

// File: tb/tb_mudv_ctl.sv
// Directed self-checking bench for mudv_ctl with hand-computed expectations.
module tb_mudv_ctl;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mudv_ctl_if bus ();

  mudv_ctl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.wen   = 2'b00;
    bus.rsel  = 2'b00;
  endtask

  // Launch one op, check busy every cycle with old HI/LO, then the commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
    #1;
    chk({tag, "_busy_pre"}, {31'd0, bus.busy}, 32'd0);
    tick();
    idle_inputs();
    for (int k = 1; k <= lat; k++) begin
      #1;
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_stall_quiet"}, {31'd0, bus.stall}, 32'd0);
      chk({tag, "_hi_old"}, bus.hi, exp_hi);
      tick();
    end
    exp_hi = new_hi;
    exp_lo = new_lo;
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_hi  = 32'd0;
    exp_lo  = 32'd0;
    rst_n   = 1'b0;
    idle_inputs();
    bus.rs  = 32'd0;
    bus.rt  = 32'd0;
    #22;
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_hi",    bus.hi,    32'd0);
    chk("rst_lo",    bus.lo,    32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mult",  3'b000, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",   3'b010, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf",3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",  3'b011, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);

    // Hazard: div 100/-7 -> q=-14, r=2; early start and move-from must stall.
    bus.start = 1'b1; bus.op = 3'b010; bus.rs = 32'd100; bus.rt = 32'hFFFF_FFF9;
    tick();                                   // accepted at t, now t+1
    idle_inputs();
    tick();                                   // t+2
    bus.start = 1'b1; bus.op = 3'b000; bus.rs = 32'd3; bus.rt = 32'd3;
    #1;
    chk("hz_start_stall", {31'd0, bus.stall}, 32'd1);
    tick();                                   // t+3
    bus.start = 1'b0; bus.rsel = 2'b10;
    for (int c = 3; c <= 10; c++) begin
      #1;
      chk("hz_rsel_stall", {31'd0, bus.stall}, 32'd1);
      chk("hz_rdata_old",  bus.rdata, 32'd2);
      tick();
    end
    #1;                                       // t+11
    chk("hz_stall_off", {31'd0, bus.stall}, 32'd0);
    chk("hz_busy_off",  {31'd0, bus.busy},  32'd0);
    chk("hz_rdata_new", bus.rdata, 32'd2);
    chk("hz_lo_new",    bus.lo, 32'hFFFF_FFF2);
    exp_hi = 32'd2;
    exp_lo = 32'hFFFF_FFF2;
    idle_inputs();

    // Move-to / move-from.
    bus.wen = 2'b10; bus.rs = 32'h1234_5678;
    tick();
    bus.wen = 2'b00;
    #1;
    chk("mthi", bus.hi, 32'h1234_5678);
    chk("mthi_lo_kept", bus.lo, 32'hFFFF_FFF2);
    bus.wen = 2'b01; bus.rs = 32'hCAFE_BABE;
    tick();
    bus.wen = 2'b00; bus.rsel = 2'b01;
    #1;
    chk("mflo_rdata", bus.rdata, 32'hCAFE_BABE);
    chk("mflo_stall", {31'd0, bus.stall}, 32'd0);
    bus.rsel = 2'b10;
    #1;
    chk("mfhi_rdata", bus.rdata, 32'h1234_5678);
    bus.rsel = 2'b11;
    #1;
    chk("mf_none", bus.rdata, 32'd0);
    bus.rsel = 2'b00;
    bus.wen = 2'b11; bus.rs = 32'hDEAD_BEEF;
    tick();
    bus.wen = 2'b00;
    #1;
    chk("wen11_hi", bus.hi, 32'h1234_5678);
    chk("wen11_lo", bus.lo, 32'hCAFE_BABE);
    exp_hi = 32'h1234_5678;
    exp_lo = 32'hCAFE_BABE;

    run_op("divu0", 3'b011, 32'd5, 32'd0, DIV_LAT, 32'h1234_5678, 32'hCAFE_BABE);
    run_op("div0",  3'b010, 32'hFFFF_FFF0, 32'd0, DIV_LAT, 32'h1234_5678, 32'hCAFE_BABE);

    // Reserved op must not start anything.
    bus.start = 1'b1; bus.op = 3'b110; bus.rs = 32'd9; bus.rt = 32'd9;
    tick();
    idle_inputs();
    #1;
    chk("rsvd_busy", {31'd0, bus.busy}, 32'd0);
    chk("rsvd_hi",   bus.hi, 32'h1234_5678);

    // Start plus move-to in IDLE: start wins.
    bus.start = 1'b1; bus.op = 3'b000; bus.wen = 2'b10; bus.rs = 32'd6; bus.rt = 32'd7;
    tick();
    idle_inputs();
    #1;
    chk("startwen_busy", {31'd0, bus.busy}, 32'd1);
    chk("startwen_hi",   bus.hi, 32'h1234_5678);
    for (int k = 1; k <= MUL_LAT; k++) tick();
    chk("startwen_lo",   bus.lo, 32'd42);
    chk("startwen_hi2",  bus.hi, 32'd0);

    // Reset in the 4th busy cycle of a div.
    bus.start = 1'b1; bus.op = 3'b010; bus.rs = 32'd50; bus.rt = 32'd5;
    tick();
    idle_inputs();
    tick(); tick(); tick();                   // t+4
    bus.wen = 2'b10; bus.rs = 32'h5555_0000;
    bus.wen = 2'b00;
    #1;
    chk("abort_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi",   bus.hi, 32'd0);
    chk("abort_lo",   bus.lo, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    run_op("post_rst", 3'b000, 32'hFFFF_FFFD, 32'd4, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
